// File: rtl/pc_predict_ctrl.sv
// pc_predict_ctrl: fetch-stage PC generation with a 2-bit saturating-counter
// branch history table. Conditional branches are resolved against the {N,V,Z}
// flags. A mispredict flushes the pipe and redirects the PC. Saturating
// counters record resolved branches and mispredicts.
module pc_predict_ctrl #(
   parameter int                ADDR_W    = 16,
   parameter int                OFF_W     = 9,
   parameter int                INC       = 2,
   parameter int                BHT_DEPTH = 16,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              if_is_br,
   input  logic [OFF_W-1:0]  if_off,
   input  logic              br_valid,
   input  logic [2:0]        br_cond,
   input  logic [OFF_W-1:0]  br_off,
   input  logic [ADDR_W-1:0] br_pc,
   input  logic              br_pred_taken,
   input  logic [2:0]        flags,
   input  logic              flag_busy,
   output logic [ADDR_W-1:0] pc,
   output logic              pred_taken,
   output logic              br_ready,
   output logic              flush,
   output logic [CNT_W-1:0]  br_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int IDX_W = $clog2(BHT_DEPTH);
   localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Branch target: address of the next sequential instruction plus the word
   // offset converted to bytes. Wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] tgt(input logic [ADDR_W-1:0] a,
                                             input logic [OFF_W-1:0]  o);
      logic [ADDR_W-1:0] ext;
      ext = {{(ADDR_W-OFF_W){o[OFF_W-1]}}, o};
      return a + INC_V + (ext << 1);
   endfunction

   logic [1:0]        bht [BHT_DEPTH];
   logic [IDX_W-1:0]  fetch_idx;
   logic [IDX_W-1:0]  br_idx;
   logic              flag_n;
   logic              flag_v;
   logic              flag_z;
   logic              taken;
   logic              resolve;
   logic [1:0]        bht_cur;
   logic [1:0]        bht_upd;
   logic [ADDR_W-1:0] redirect;
   logic [ADDR_W-1:0] pc_next;

   // The byte-offset bit 0 is skipped, so consecutive instructions map to
   // consecutive entries.
   assign fetch_idx = pc[IDX_W:1];
   assign br_idx    = br_pc[IDX_W:1];
   assign flag_n    = flags[2];
   assign flag_v    = flags[1];
   assign flag_z    = flags[0];

   // The resolve stage waits until no older flag writer is in flight.
   assign br_ready  = ~flag_busy;
   assign resolve   = br_valid & br_ready;

   // Evaluate the branch condition code against the current flags.
   always_comb begin
      taken = 1'b0;
      case (br_cond)
         3'b000: taken = ~flag_z;
         3'b001: taken = flag_z;
         3'b010: taken = ~flag_z & ~flag_n;
         3'b011: taken = flag_n;
         3'b100: taken = flag_z | ~flag_n;
         3'b101: taken = flag_z | flag_n;
         3'b110: taken = flag_v;
         default: taken = 1'b1;
      endcase
   end

   // Fetch reads the pre-update counter. A same-cycle write lands at the edge.
   assign pred_taken = ~rst & if_is_br & bht[fetch_idx][1];
   assign flush      = ~rst & resolve & (taken != br_pred_taken);
   assign redirect   = taken ? tgt(br_pc, br_off) : (br_pc + INC_V);

   // Compute the saturating counter step for the resolving branch's entry.
   always_comb begin
      bht_cur = bht[br_idx];
      bht_upd = bht_cur;
      if (taken) begin
         if (bht_cur != 2'b11) bht_upd = bht_cur + 2'b01;
      end else begin
         if (bht_cur != 2'b00) bht_upd = bht_cur - 2'b01;
      end
   end

   // Select the next PC: redirect, then stall, then predicted target, then sequential.
   always_comb begin
      pc_next = pc + INC_V;
      if (flush)
         pc_next = redirect;
      else if (stall)
         pc_next = pc;
      else if (pred_taken)
         pc_next = tgt(pc, if_off);
   end

   // Hold the architectural fetch PC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc <= RESET_PC;
      else
         pc <= pc_next;
   end

   // Train the history table on each resolved branch. Reset makes every entry weakly not taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_DEPTH; i++)
            bht[i] <= 2'b01;
      end else if (resolve) begin
         bht[br_idx] <= bht_upd;
      end
   end

   // Count resolved branches and mispredicts. Both counters saturate at all ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_cnt   <= '0;
         miss_cnt <= '0;
      end else begin
         if (resolve && (br_cnt != '1))
            br_cnt <= br_cnt + CNT_ONE;
         if (flush && (miss_cnt != '1))
            miss_cnt <= miss_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pc_predict_ctrl.sv
// Testbench for pc_predict_ctrl: a table of resolve vectors covering every
// condition code, plus hand-written sequences for reset, stall, flag wait,
// BHT training, PC wrap and flush-over-stall.
module tb_pc_predict_ctrl;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        if_is_br;
   logic [8:0]  if_off;
   logic        br_valid;
   logic [2:0]  br_cond;
   logic [8:0]  br_off;
   logic [15:0] br_pc;
   logic        br_pred_taken;
   logic [2:0]  flags;
   logic        flag_busy;
   logic [15:0] pc;
   logic        pred_taken;
   logic        br_ready;
   logic        flush;
   logic [15:0] br_cnt;
   logic [15:0] miss_cnt;

   int n_chk;
   int n_fail;

   pc_predict_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .if_is_br     (if_is_br),
      .if_off       (if_off),
      .br_valid     (br_valid),
      .br_cond      (br_cond),
      .br_off       (br_off),
      .br_pc        (br_pc),
      .br_pred_taken(br_pred_taken),
      .flags        (flags),
      .flag_busy    (flag_busy),
      .pc           (pc),
      .pred_taken   (pred_taken),
      .br_ready     (br_ready),
      .flush        (flush),
      .br_cnt       (br_cnt),
      .miss_cnt     (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  cond;
      logic [2:0]  flg;     // {N,V,Z}
      logic        pred;
      logic        exp_flush;
      logic [15:0] exp_pc;
      logic [15:0] exp_br;
      logic [15:0] exp_miss;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_br(input logic [2:0] c, input logic [2:0] f, input logic p,
                         input logic [15:0] a, input logic [8:0] o);
      br_valid      = 1'b1;
      br_cond       = c;
      flags         = f;
      br_pred_taken = p;
      br_pc         = a;
      br_off        = o;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      // Each row resolves at br_pc=0x0200 with off=0x010.
      // The taken target is 0x0222. The not-taken target is 0x0202.
      // Stall is held, so pc moves only on a flush.
      vecs[0]  = '{3'b000, 3'b000, 1'b1, 1'b0, 16'h3289, 16'd2,  16'd1};
      vecs[1]  = '{3'b001, 3'b000, 1'b0, 1'b0, 16'h3289, 16'd3,  16'd1};
      vecs[2]  = '{3'b010, 3'b100, 1'b1, 1'b1, 16'h0202, 16'd4,  16'd2};
      vecs[3]  = '{3'b011, 3'b100, 1'b0, 1'b1, 16'h0222, 16'd5,  16'd3};
      vecs[4]  = '{3'b100, 3'b101, 1'b1, 1'b0, 16'h0222, 16'd6,  16'd3};
      vecs[5]  = '{3'b101, 3'b000, 1'b1, 1'b1, 16'h0202, 16'd7,  16'd4};
      vecs[6]  = '{3'b110, 3'b010, 1'b0, 1'b1, 16'h0222, 16'd8,  16'd5};
      vecs[7]  = '{3'b110, 3'b101, 1'b0, 1'b0, 16'h0222, 16'd9,  16'd5};
      vecs[8]  = '{3'b111, 3'b000, 1'b1, 1'b0, 16'h0222, 16'd10, 16'd5};
      vecs[9]  = '{3'b010, 3'b000, 1'b1, 1'b0, 16'h0222, 16'd11, 16'd5};
      vecs[10] = '{3'b000, 3'b001, 1'b0, 1'b0, 16'h0222, 16'd12, 16'd5};

      rst = 1'b1; stall = 1'b0; if_is_br = 1'b0; if_off = '0;
      br_valid = 1'b0; br_cond = '0; br_off = '0; br_pc = '0;
      br_pred_taken = 1'b0; flags = '0; flag_busy = 1'b0;

      // Initial reset: outputs held quiet even with a would-be mispredict present.
      repeat (2) tick();
      chk("rst_pc", pc, 16'h0000);
      chk("rst_br_cnt", br_cnt, 16'd0);
      chk("rst_miss_cnt", miss_cnt, 16'd0);
      set_br(3'b111, 3'b000, 1'b0, 16'h0000, 9'h000);
      if_is_br = 1'b1;
      #1;
      chk("rst_flush", {15'd0, flush}, 16'd0);
      chk("rst_pred", {15'd0, pred_taken}, 16'd0);
      br_valid = 1'b0; if_is_br = 1'b0;
      rst = 1'b0;
      chk("rel_pc0", pc, 16'h0000);
      tick(); chk("rel_pc1", pc, 16'h0002);
      tick(); chk("rel_pc2", pc, 16'h0004);

      // Stall holds pc at 0x0004 for 3 cycles.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); chk("stall_hold", pc, 16'h0004);
      end
      stall = 1'b0;
      tick(); chk("stall_release", pc, 16'h0006);

      // Mispredict: predicted not taken, resolves taken with a negative offset.
      set_br(3'b000, 3'b000, 1'b0, 16'h3333, 9'h1AA);
      #1; chk("mp_flush", {15'd0, flush}, 16'd1);
      tick(); br_valid = 1'b0;
      chk("mp_pc", pc, 16'h3289);
      chk("mp_br_cnt", br_cnt, 16'd1);
      chk("mp_miss_cnt", miss_cnt, 16'd1);

      // Table of condition codes.
      stall = 1'b1;
      for (int i = 0; i < 11; i++) begin
         set_br(vecs[i].cond, vecs[i].flg, vecs[i].pred, 16'h0200, 9'h010);
         #1;
         chk($sformatf("vec%0d_flush", i), {15'd0, flush}, {15'd0, vecs[i].exp_flush});
         tick();
         chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
         chk($sformatf("vec%0d_br_cnt", i), br_cnt, vecs[i].exp_br);
         chk($sformatf("vec%0d_miss_cnt", i), miss_cnt, vecs[i].exp_miss);
      end

      // Redirect to 0xFFFE, then the sequential increment wraps to 0.
      set_br(3'b111, 3'b000, 1'b0, 16'hFFE0, 9'h00E);
      #1; chk("wrap_flush", {15'd0, flush}, 16'd1);
      tick(); br_valid = 1'b0;
      chk("wrap_tgt", pc, 16'hFFFE);
      stall = 1'b0;
      tick(); chk("wrap_pc", pc, 16'h0000);
      stall = 1'b1;

      // Training at 0x0010. The first resolve cycle sees the old counter.
      set_br(3'b111, 3'b000, 1'b0, 16'h000E, 9'h000);
      tick(); chk("train_redirect", pc, 16'h0010);
      set_br(3'b111, 3'b000, 1'b1, 16'h0010, 9'h000);
      if_is_br = 1'b1; if_off = 9'h004;
      #1;
      chk("train_flush", {15'd0, flush}, 16'd0);
      chk("train_pred_old", {15'd0, pred_taken}, 16'd0);
      tick();
      chk("train_pred_new", {15'd0, pred_taken}, 16'd1);
      tick();
      br_valid = 1'b0; stall = 1'b0;
      #1; chk("train_pred", {15'd0, pred_taken}, 16'd1);
      tick(); chk("train_pc", pc, 16'h001A);
      chk("train_br_cnt", br_cnt, 16'd16);
      stall = 1'b1; if_is_br = 1'b0;

      // Flag wait: the mispredict stays pending while flag_busy is high.
      set_br(3'b111, 3'b000, 1'b0, 16'h0082, 9'h000);
      flag_busy = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("wait_ready", {15'd0, br_ready}, 16'd0);
         chk("wait_flush", {15'd0, flush}, 16'd0);
         tick();
         chk("wait_br_cnt", br_cnt, 16'd16);
         chk("wait_miss_cnt", miss_cnt, 16'd7);
         chk("wait_pc", pc, 16'h001A);
      end
      flag_busy = 1'b0;
      #1;
      chk("wait_ready_rise", {15'd0, br_ready}, 16'd1);
      chk("wait_flush_rise", {15'd0, flush}, 16'd1);
      tick();
      chk("wait_pc_redirect", pc, 16'h0084);
      chk("wait_br_cnt_done", br_cnt, 16'd17);
      chk("wait_miss_cnt_done", miss_cnt, 16'd8);

      // Flush beats stall: cond 100, N=1, Z=0 resolves not taken against a taken prediction.
      set_br(3'b100, 3'b100, 1'b1, 16'h0100, 9'h000);
      #1; chk("fbs_flush", {15'd0, flush}, 16'd1);
      tick();
      chk("fbs_pc", pc, 16'h0102);
      chk("fbs_miss_cnt", miss_cnt, 16'd9);
      // Second not-taken resolve on the same entry (10 -> 01 if the first decremented).
      set_br(3'b001, 3'b000, 1'b0, 16'h0100, 9'h000);
      #1; chk("dec_flush", {15'd0, flush}, 16'd0);
      tick(); chk("dec_br_cnt", br_cnt, 16'd19);
      // Redirect to 0x0040 (entry 0) and check the decremented prediction.
      set_br(3'b111, 3'b000, 1'b0, 16'h003E, 9'h000);
      tick(); br_valid = 1'b0;
      chk("pre_rst_pc", pc, 16'h0040);
      chk("pre_rst_miss_cnt", miss_cnt, 16'd10);
      if_is_br = 1'b1; if_off = 9'h004;
      #1; chk("dec_pred", {15'd0, pred_taken}, 16'd0);

      // Asynchronous reset mid-cycle at pc=0x0040.
      #2 rst = 1'b1;
      #1;
      chk("async_rst_pc", pc, 16'h0000);
      chk("async_rst_br_cnt", br_cnt, 16'd0);
      chk("async_rst_miss_cnt", miss_cnt, 16'd0);
      stall = 1'b0; if_is_br = 1'b0;
      tick();
      rst = 1'b0;
      chk("post_rst_pc0", pc, 16'h0000);
      tick(); chk("post_rst_pc1", pc, 16'h0002);
      tick(); chk("post_rst_pc2", pc, 16'h0004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
